sqrt_sched: RTL and testbench

Shared, time-multiplexed integer square-root engine with a round-robin arbiter. Up to four requesters present 2n-bit operands. The block grants one requester at a time and computes the root bit-serially, one result bit per clock, using restoring subtraction. It returns the n-bit root and the residual error (operand − root²) tagged with the requester ID. It replaces per-client combinational square-root/error logic where area matters more than throughput.

---
 rtl/sqrt_sched.sv | 115 +++++++++++
 tb/tb_sqrt_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin shared bit-serial integer square-root engine returning root and residual
module sqrt_sched #(
  parameter int ASIZE = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ASIZE-1:0] a_bus,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            done_id,
  output logic [ASIZE/2-1:0]    root,
  output logic [ASIZE/2:0]      err
);
  localparam int H  = ASIZE / 2;
  localparam int IW = $clog2(H);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            st_q, st_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ASIZE-1:0]  v_q, v_d, r_q, r_d, tt;
  logic [IW-1:0]     i_q, i_d;
  logic [1:0]        id_q, id_d, last_q, last_d, did_q, did_d, win;
  logic [H-1:0]      root_q, root_d;
  logic [H:0]        err_q, err_d;
  // lowest k wins, so the search effectively starts just after last_q
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(last_q) + 1 + k) % NREQ]) win = 2'((int'(last_q) + 1 + k) % NREQ);
  end
  assign tt = (v_q << i_q << 1) | (ASIZE'(1) << {i_q, 1'b0});
  always_comb begin
    st_d   = st_q;
    gnt_d  = '0;
    busy_d = busy_q;
    done_d = 1'b0;
    v_d    = v_q;
    r_d    = r_q;
    i_d    = i_q;
    id_d   = id_q;
    last_d = last_q;
    did_d  = did_q;
    root_d = root_q;
    err_d  = err_q;
    case (st_q)
      IDLE: if (|req) begin
        gnt_d  = NREQ'(1) << win;
        id_d   = win;
        last_d = win;
        v_d    = '0;
        r_d    = a_bus[win*ASIZE +: ASIZE];
        i_d    = IW'(H - 1);
        busy_d = 1'b1;
        st_d   = CALC;
      end
      CALC: begin
        if (tt <= r_q) begin
          v_d = v_q | (ASIZE'(1) << i_q);
          r_d = r_q - tt;
        end
        if (i_q == '0) begin
          st_d   = DONE;
          done_d = 1'b1;
          root_d = v_d[H-1:0];
          err_d  = r_d[H:0];
          did_d  = id_q;
        end else begin
          i_d = i_q - IW'(1);
        end
      end
      default: begin
        st_d   = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      v_q    <= '0;
      r_q    <= '0;
      i_q    <= '0;
      id_q   <= '0;
      last_q <= 2'(NREQ - 1);
      did_q  <= '0;
      root_q <= '0;
      err_q  <= '0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      v_q    <= v_d;
      r_q    <= r_d;
      i_q    <= i_d;
      id_q   <= id_d;
      last_q <= last_d;
      did_q  <= did_d;
      root_q <= root_d;
      err_q  <= err_d;
    end
  end
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = did_q;
  assign root    = root_q;
  assign err     = err_q;
endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched: scoreboard bench for the shared square-root engine with directed vectors and a sweep
module tb_sqrt_sched;
  localparam int A = 8, N = 4, H = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*A-1:0] a_bus = '0;
  logic [N-1:0] gnt;
  logic busy, done;
  logic [1:0] done_id;
  logic [H-1:0] root;
  logic [H:0] err;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int id; int rt; int er;} exp_t;
  exp_t q[$];

  sqrt_sched #(.ASIZE(A), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .root(root), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (gnt != 0 && done) chk("gnt_done_overlap", 1, 0);
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_id", int'(done_id), e.id);
        chk("root", int'(root), e.rt);
        chk("err", int'(err), e.er);
      end
    end
  end

  task automatic push_exp(input int id, input int rt, input int er);
    exp_t e;
    e.id = id; e.rt = rt; e.er = er;
    q.push_back(e);
  endtask

  task automatic model(input int a, output int rt, output int er);
    rt = 0;
    while ((rt + 1) * (rt + 1) <= a) rt++;
    er = a - rt * rt;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (gnt != 0) begin ok = 1'b1; return; end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done_latency();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 10);
    chk("done_latency", n, 4);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic issue(input int id, input int a, input int rt, input int er);
    bit ok;
    a_bus[id*A +: A] = A'(a);
    req[id] = 1'b1;
    wait_gnt(ok);
    req[id] = 1'b0;
    if (!ok) return;
    chk("gnt", int'(gnt), 1 << id);
    push_exp(id, rt, er);
    wait_done_latency();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    int t, rt, er;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_root", int'(root), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done_id", int'(done_id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 200, 14, 4);
    issue(2, 0, 0, 0);
    issue(2, 255, 15, 30);
    issue(2, 144, 12, 0);
    issue(2, 1, 1, 0);
    issue(2, 3, 1, 2);
    // all four requesting straight out of reset
    @(negedge clk);
    rst_n = 1'b0;
    a_bus = {8'd255, 8'd99, 8'd50, 8'd200};
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      if (!ok) break;
      chk("rr_gnt", int'(gnt), 1 << k);
      if (k > 0) chk("rr_spacing", cyc - t, 6);
      t = cyc;
      req[k] = 1'b0;
      model(int'(a_bus[k*A +: A]), rt, er);
      push_exp(k, rt, er);
    end
    req = '0;
    wait_idle();
    // two requesters held continuously must alternate
    a_bus[0*A +: A] = 8'd16;
    a_bus[3*A +: A] = 8'd99;
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      if (!ok) break;
      chk("fair_gnt", int'(gnt), (k % 2) ? 8 : 1);
      if (k % 2) push_exp(3, 9, 18); else push_exp(0, 4, 0);
      if (k == 3) req = '0;
    end
    req = '0;
    wait_idle();
    // operand changes after capture must not matter
    a_bus[1*A +: A] = 8'd81;
    req[1] = 1'b1;
    wait_gnt(ok);
    req[1] = 1'b0;
    if (ok) begin
      chk("chg_gnt", int'(gnt), 2);
      push_exp(1, 9, 0);
      a_bus[1*A +: A] = 8'd200;
      wait_done_latency();
    end
    for (int a = 0; a < 256; a++) begin
      model(a, rt, er);
      issue(1, a, rt, er);
    end
    // reset two iterations into a calculation
    a_bus[0*A +: A] = 8'd200;
    req[0] = 1'b1;
    wait_gnt(ok);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_root", int'(root), 0);
    chk("abort_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(2, 144, 12, 0);
    wait_idle();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
